// File: rtl/adder_pkg.sv
// Shared types and geometry helpers for the pipelined ripple-carry adder family.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Legal geometry: at least 2 bits, 1..width stages, stages dividing width evenly.
  function automatic bit params_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle: master issues operands and takes results.
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell used to build ripple-carry chains.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_slice.sv
// W-bit ripple-carry slice; also exposes the carry into its top bit for overflow.
module rca_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [W:0] w_c;

  assign w_c[0] = ci;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    full_adder u_fa (
      .a  (a[gi]),
      .b  (b[gi]),
      .ci (w_c[gi]),
      .s  (s[gi]),
      .co (w_c[gi+1])
    );
  end

  assign co       = w_c[W];
  assign c_msb_in = w_c[W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: one SLICE-bit ripple segment per stage, operands skewed
// forward and finished sum slices de-skewed so the result leaves aligned.
module pipelined_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_addsub_if.slave io
);

  localparam int SLICE = slice_w(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be >= 2 and divisible by STAGES (1..WIDTH)");
  end

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_carry;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic              r_ovf;

  logic [WIDTH-1:0]               w_a_in   [STAGES];
  logic [WIDTH-1:0]               w_b_in   [STAGES];
  logic [WIDTH-1:0]               w_sum_in [STAGES];
  logic [STAGES-1:0][WIDTH-1:0]   w_sum_next;
  logic [STAGES-1:0]              w_ci;
  logic [STAGES-1:0]              w_valid_in;
  logic [STAGES-1:0]              w_co;
  logic                           w_cmsb [STAGES];
  logic                           w_advance;
  op_e                            w_op;

  assign w_op      = op_e'(io.sub);
  assign w_advance = !r_valid[STAGES-1] || io.out_ready;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [SLICE-1:0] w_s;

    if (gi == 0) begin : g_head
      // Subtraction is A + ~B + 1; cin only matters in add mode.
      assign w_a_in[gi]     = io.a;
      assign w_b_in[gi]     = (w_op == OP_SUB) ? ~io.b : io.b;
      assign w_ci[gi]       = (w_op == OP_SUB) ? 1'b1 : io.cin;
      assign w_valid_in[gi] = io.in_valid;
      assign w_sum_in[gi]   = '0;
    end else begin : g_body
      assign w_a_in[gi]     = r_a[gi-1];
      assign w_b_in[gi]     = r_b[gi-1];
      assign w_ci[gi]       = r_carry[gi-1];
      assign w_valid_in[gi] = r_valid[gi-1];
      assign w_sum_in[gi]   = r_sum[gi-1];
    end

    rca_slice #(.W(SLICE)) u_slice (
      .a        (w_a_in[gi][gi*SLICE +: SLICE]),
      .b        (w_b_in[gi][gi*SLICE +: SLICE]),
      .ci       (w_ci[gi]),
      .s        (w_s),
      .co       (w_co[gi]),
      .c_msb_in (w_cmsb[gi])
    );

    for (genvar gj = 0; gj < STAGES; gj++) begin : g_merge
      if (gj == gi) begin : g_new
        assign w_sum_next[gi][gj*SLICE +: SLICE] = w_s;
      end else begin : g_keep
        assign w_sum_next[gi][gj*SLICE +: SLICE] = w_sum_in[gi][gj*SLICE +: SLICE];
      end
    end
  end

  // Global stall: the whole pipe either advances together or holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_carry <= '0;
      r_ovf   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else if (w_advance) begin
      r_valid <= w_valid_in;
      r_carry <= w_co;
      r_ovf   <= w_co[STAGES-1] ^ w_cmsb[STAGES-1];
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
        r_sum[k] <= w_sum_next[k];
      end
    end
  end

  assign io.in_ready  = w_advance;
  assign io.out_valid = r_valid[STAGES-1];
  assign io.sum       = r_sum[STAGES-1];
  assign io.cout      = r_carry[STAGES-1];
  assign io.ovf       = r_ovf;

endmodule
